// File: rtl/cpu_defs_pkg.sv
// Shared pipeline definitions: the stall vector type and its bit indices,
// the default exception and ERET constants, the pipeline-control state
// encoding, and the stall-priority decode helper.
package cpu_defs_pkg;

  // Hold vector: bit i freezes pipeline register i.
  typedef logic [4:0] stall_vec_t;

  localparam int unsigned STALL_PC    = 0;
  localparam int unsigned STALL_IF_ID = 1;
  localparam int unsigned STALL_ID_EX = 2;
  localparam int unsigned STALL_EX_MM = 3;
  localparam int unsigned STALL_WB    = 4;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
  localparam logic [31:0] ERET_CODE  = 32'h0000_000E;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } ctrl_state_e;

  // The furthest-downstream requester wins. Every register up to and
  // including the one that feeds that stage is held. The register after
  // it keeps moving, so a bubble flows downstream.
  function automatic stall_vec_t stall_decode(input logic req_if, input logic req_id,
                                              input logic req_exe, input logic req_mem);
    stall_vec_t v;
    v = '0;
    if (req_mem)      v = 5'b01111;
    else if (req_exe) v = 5'b00111;
    else if (req_id)  v = 5'b00011;
    else if (req_if)  v = 5'b00001;
    return v;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline stages and pipeline_ctrl.
//   slave  : the controller side. It receives the stall requests, the
//            exception and ERET information and if_busy, and it drives the
//            stall, flush and redirect outputs and the performance counter.
//   master : the pipeline side, with the opposite directions.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import cpu_defs_pkg::*;

  logic             stallreq_if_i;
  logic             stallreq_id_i;
  logic             stallreq_exe_i;
  logic             stallreq_mem_i;
  logic             if_busy_i;
  logic             exc_valid_i;
  logic [31:0]      exc_code_i;
  logic [31:0]      cp0_epc_i;
  stall_vec_t       stall_o;
  logic             flush_o;
  logic             redirect_o;
  logic [31:0]      new_pc_o;
  logic             busy_o;
  logic [CNT_W-1:0] stall_cycles_o;

  modport slave (
    input  stallreq_if_i, stallreq_id_i, stallreq_exe_i, stallreq_mem_i,
           if_busy_i, exc_valid_i, exc_code_i, cp0_epc_i,
    output stall_o, flush_o, redirect_o, new_pc_o, busy_o, stall_cycles_o
  );

  modport master (
    output stallreq_if_i, stallreq_id_i, stallreq_exe_i, stallreq_mem_i,
           if_busy_i, exc_valid_i, exc_code_i, cp0_epc_i,
    input  stall_o, flush_o, redirect_o, new_pc_o, busy_o, stall_cycles_o
  );

endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
//   clk, rst : clock and synchronous active-high reset
//   bus      : pipeline_ctrl_if.slave
//              inputs : stall requests from IF/ID/EXE/MEM, if_busy, and the
//                       exception valid/code and EPC from MEM
//              outputs: stall_o (per-register hold), flush_o, the redirect_o
//                       pulse with new_pc_o, busy_o (a redirect is pending),
//                       and the saturating stall_cycles_o counter
// An exception flushes the pipeline immediately. If a fetch is still in
// flight, the redirect waits in HOLD with the PC frozen until the fetch
// completes.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR = cpu_defs_pkg::EXC_VECTOR,
  parameter logic [31:0] ERET_CODE  = cpu_defs_pkg::ERET_CODE,
  parameter int unsigned CNT_W      = 32
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.slave bus
);
  import cpu_defs_pkg::*;

  ctrl_state_e      state_q, state_d;
  logic [31:0]      target_q;
  logic [31:0]      exc_target;
  logic [CNT_W-1:0] cnt_q;

  stall_vec_t  stall;
  logic        flush, redirect, busy;
  logic [31:0] new_pc;

  assign exc_target = (bus.exc_code_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;

  // Outputs are held at zero while rst is asserted, so nothing leaks out
  // during the reset cycle, including a pending redirect.
  always_comb begin
    state_d  = state_q;
    stall    = '0;
    flush    = 1'b0;
    redirect = 1'b0;
    new_pc   = '0;
    busy     = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (bus.exc_valid_i) begin
            flush = 1'b1;
            if (!bus.if_busy_i) begin
              redirect = 1'b1;
              new_pc   = exc_target;
            end else begin
              state_d = HOLD;
            end
          end else begin
            stall = stall_decode(bus.stallreq_if_i, bus.stallreq_id_i,
                                 bus.stallreq_exe_i, bus.stallreq_mem_i);
          end
        end
        HOLD: begin
          // In HOLD the exception input is ignored. MEM is being flushed,
          // so any exception it reports here comes from a wrong-path
          // instruction.
          busy            = 1'b1;
          flush           = 1'b1;
          stall[STALL_PC] = 1'b1;
          if (!bus.if_busy_i) begin
            redirect = 1'b1;
            new_pc   = target_q;
            state_d  = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN && bus.exc_valid_i)
        target_q <= exc_target;
      if (stall[STALL_PC] && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.stall_o        = stall;
  assign bus.flush_o        = flush;
  assign bus.redirect_o     = redirect;
  assign bus.new_pc_o       = new_pc;
  assign bus.busy_o         = busy;
  assign bus.stall_cycles_o = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl. Each cycle, inputs are driven after
// the falling edge. The expected outputs are derived from a reference model
// and queued. Before the next rising edge, the entry is popped and compared
// with the DUT outputs.
module tb_pipeline_ctrl;

  localparam int unsigned CW = 4;
  localparam logic [31:0] VEC  = 32'hBFC0_0380;
  localparam logic [31:0] ERET = 32'h0000_000E;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_ctrl #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string       tag;
    logic [4:0]  stall;
    logic        flush;
    logic        redirect;
    logic [31:0] new_pc;
    logic        busy;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic          m_hold;
  logic [31:0]   m_target;
  logic [CW-1:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".stall"},    32'(bus.stall_o),        32'(e.stall));
    check({e.tag, ".flush"},    32'(bus.flush_o),        32'(e.flush));
    check({e.tag, ".redirect"}, 32'(bus.redirect_o),     32'(e.redirect));
    check({e.tag, ".new_pc"},   bus.new_pc_o,            e.new_pc);
    check({e.tag, ".busy"},     32'(bus.busy_o),         32'(e.busy));
    check({e.tag, ".cnt"},      32'(bus.stall_cycles_o), 32'(e.cnt));
  endtask

  // req = {mem, exe, id, if}
  task automatic step(input string tag, input logic r, input logic [3:0] req,
                      input logic ifb, input logic exc,
                      input logic [31:0] code, input logic [31:0] epc);
    exp_t e;
    logic [31:0] tgt;
    @(negedge clk);
    rst                = r;
    bus.stallreq_if_i  = req[0];
    bus.stallreq_id_i  = req[1];
    bus.stallreq_exe_i = req[2];
    bus.stallreq_mem_i = req[3];
    bus.if_busy_i      = ifb;
    bus.exc_valid_i    = exc;
    bus.exc_code_i     = code;
    bus.cp0_epc_i      = epc;

    tgt        = (code == ERET) ? epc : VEC;
    e.tag      = tag;
    e.stall    = 5'b0;
    e.flush    = 1'b0;
    e.redirect = 1'b0;
    e.new_pc   = 32'h0;
    e.busy     = 1'b0;
    e.cnt      = m_cnt;
    if (!r) begin
      if (m_hold) begin
        e.stall = 5'b00001; e.flush = 1'b1; e.busy = 1'b1;
        if (!ifb) begin e.redirect = 1'b1; e.new_pc = m_target; end
      end else if (exc) begin
        e.flush = 1'b1;
        if (!ifb) begin e.redirect = 1'b1; e.new_pc = tgt; end
      end else if (req[3]) e.stall = 5'b01111;
      else if (req[2])     e.stall = 5'b00111;
      else if (req[1])     e.stall = 5'b00011;
      else if (req[0])     e.stall = 5'b00001;
    end
    sb.push_back(e);

    #3;
    compare_out();
    @(posedge clk);
    if (r) begin
      m_hold = 1'b0; m_target = 32'h0; m_cnt = '0;
    end else begin
      if (e.stall[0] && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      if (!m_hold && exc) m_target = tgt;
      m_hold = m_hold ? ifb : (exc && ifb);
    end
  endtask

  initial begin
    m_hold = 1'b0; m_target = 32'h0; m_cnt = '0;
    rst = 1'b1;
    bus.stallreq_if_i = 0; bus.stallreq_id_i = 0; bus.stallreq_exe_i = 0;
    bus.stallreq_mem_i = 0; bus.if_busy_i = 0; bus.exc_valid_i = 0;
    bus.exc_code_i = 0; bus.cp0_epc_i = 0;

    step("rst0", 1, 4'b0000, 0, 0, 0, 0);
    step("rst1", 1, 4'b1111, 1, 1, 4, 0);
    step("idle", 0, 4'b0000, 0, 0, 0, 0);
    step("t1_id",     0, 4'b0010, 0, 0, 0, 0);
    step("t2_if_mem", 0, 4'b1001, 0, 0, 0, 0);
    step("exe_only",  0, 4'b0100, 0, 0, 0, 0);
    step("if_only",   0, 4'b0001, 0, 0, 0, 0);
    step("all_req",   0, 4'b1111, 0, 0, 0, 0);
    step("t3_exc",    0, 4'b0000, 0, 1, 32'h4, 0);
    step("t4_eret",   0, 4'b0000, 1, 1, ERET, 32'h8000_1234);
    step("t4_wait1",  0, 4'b1000, 1, 1, 32'h4, 0);
    step("t4_wait2",  0, 4'b0000, 1, 0, 0, 0);
    step("t4_redir",  0, 4'b0000, 0, 0, 0, 0);
    step("t4_after",  0, 4'b0000, 0, 0, 0, 0);
    step("t5_exe_exc", 0, 4'b0100, 0, 1, 32'h8, 0);
    step("t6_exc",    0, 4'b0000, 1, 1, 32'h4, 0);
    step("t6_hold",   0, 4'b0000, 1, 0, 0, 0);
    step("t6_rst",    1, 4'b0000, 1, 0, 0, 0);
    step("t6_after",  0, 4'b0000, 0, 0, 0, 0);
    step("t6_after2", 0, 4'b0000, 0, 0, 0, 0);

    for (int i = 0; i < 10; i++) step("cnt_run", 0, 4'b0001, 0, 0, 0, 0);
    step("cnt_idle", 0, 4'b0000, 0, 0, 0, 0);
    check("cnt_10", 32'(bus.stall_cycles_o), 32'd10);
    for (int i = 0; i < 8; i++) step("cnt_sat_run", 0, 4'b1000, 0, 0, 0, 0);
    step("cnt_sat_idle", 0, 4'b0000, 0, 0, 0, 0);
    check("cnt_sat", 32'(bus.stall_cycles_o), 32'd15);

    for (int i = 0; i < 60; i++) begin
      logic [3:0]  rq;
      logic        ex;
      logic [31:0] cd;
      rq = 4'($urandom);
      ex = ($urandom_range(0, 5) == 0);
      cd = ($urandom_range(0, 1) == 0) ? ERET : 32'($urandom_range(0, 31));
      step("rand", 0, rq, 1'($urandom), ex, cd, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
